// File: rtl/spi_ram_sp.sv
// spi_ram_sp: single-port byte RAM driven by 10-bit SPI slave command words.
// din[9:8] selects the command: 00 set write address, 01 write byte,
// 10 set read address, 11 read byte (returned on dout with a tx_valid pulse).
// Build option: define RAM_ADDR_AUTOINC_EN to post-increment wr_addr after
// WR_DATA and rd_addr after RD_DATA, wrapping MEM_DEPTH-1 (or any
// out-of-range address) back to 0.
//
// Handshake: rx_valid is a level from the SPI slave. A command executes only
// on its rising edge, so a level held high runs once. tx_valid is a one-cycle
// pulse that marks dout as fresh read data. dout then holds until the next
// read. There is no backpressure in either direction.
module spi_ram_sp #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic                 rx_valid_q;
    logic                 cmd_go;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [7:0]           mem [MEM_DEPTH];

    // Rising-edge detection of rx_valid. rx_valid_q resets low, so a level
    // that is already high at reset release counts as a fresh command.
    assign cmd_go = rx_valid & ~rx_valid_q;
    assign opcode = din[9:8];

    // Addresses past MEM_DEPTH are legal register values and must not touch
    // the array. The index is trimmed to the array's own width.
    assign wr_in_range = 32'(wr_addr) < 32'(MEM_DEPTH);
    assign rd_in_range = 32'(rd_addr) < 32'(MEM_DEPTH);
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

`ifdef RAM_ADDR_AUTOINC_EN
    // Next sequential address. The last location and any out-of-range
    // address both wrap to 0.
    function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) >= 32'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction
`endif

    // Edge-detect register and the write/read address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (cmd_go) begin
                case (opcode)
                    OP_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
                    OP_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
`ifdef RAM_ADDR_AUTOINC_EN
                    OP_WR_DATA: wr_addr <= wrap_inc(wr_addr);
                    OP_RD_DATA: rd_addr <= wrap_inc(rd_addr);
`endif
                    default: ;
                endcase
            end
        end
    end

    // Memory array write. It is not reset, so contents survive rst_n.
    // Out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (cmd_go && (opcode == OP_WR_DATA) && wr_in_range) begin
            mem[wr_idx] <= din[7:0];
        end
    end

    // Read port. tx_valid pulses for one cycle per RD_DATA strobe, and dout
    // holds the last read. Out-of-range reads return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= cmd_go && (opcode == OP_RD_DATA);
            if (cmd_go && (opcode == OP_RD_DATA)) begin
                dout <= rd_in_range ? mem[rd_idx] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_sp.sv
// tb_spi_ram_sp: drives a 256-deep and a 128-deep spi_ram_sp from the same
// command stream and compares both against a command-level memory model.
// Follows RAM_ADDR_AUTOINC_EN when it is defined.
module tb_spi_ram_sp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       tx0;
    logic       tx1;

    spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_ram256 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout0), .tx_valid(tx0)
    );

    spi_ram_sp #(.MEM_DEPTH(128), .ADDR_SIZE(8)) u_ram128 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout1), .tx_valid(tx1)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Scoreboard and model state.
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;
    int         depth[2] = '{256, 128};
    logic [7:0] model_mem[2][256];
    int         wa[2];
    int         ra[2];
    bit         prev_rxv;
    bit         exp_tx[2];
    logic [7:0] exp_dout[2];
    logic [7:0] exp_q[$];
    int         pulses[2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        prev_rxv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wa[k]       = 0;
            ra[k]       = 0;
            exp_tx[k]   = 1'b0;
            exp_dout[k] = 8'h00;
        end
        exp_q.delete();
    endtask

    // Apply the command rules to the inputs seen at this rising edge.
    task automatic model_step();
        bit go;
        if (!rst_n) begin
            model_reset();
            return;
        end
        go = rx_valid && !prev_rxv;
        prev_rxv = rx_valid;
        for (int k = 0; k < 2; k++) begin
            exp_tx[k] = 1'b0;
            if (go) begin
                case (din[9:8])
                    2'd0: wa[k] = int'(din[7:0]);
                    2'd1: begin
                        if (wa[k] < depth[k]) model_mem[k][wa[k]] = din[7:0];
`ifdef RAM_ADDR_AUTOINC_EN
                        wa[k] = (wa[k] >= depth[k] - 1) ? 0 : wa[k] + 1;
`endif
                    end
                    2'd2: ra[k] = int'(din[7:0]);
                    default: begin
                        exp_tx[k]   = 1'b1;
                        exp_dout[k] = (ra[k] < depth[k]) ? model_mem[k][ra[k]] : 8'h00;
                        if (k == 0) exp_q.push_back(exp_dout[k]);
`ifdef RAM_ADDR_AUTOINC_EN
                        ra[k] = (ra[k] >= depth[k] - 1) ? 0 : ra[k] + 1;
`endif
                    end
                endcase
            end
        end
    endtask

    // One clock: update the model at the edge, then leave time for input changes.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Hold one command on rx_valid for 'hold' cycles, then drop it for 'gap' cycles.
    task automatic send(input logic [9:0] cmd, input int hold, input int gap);
        din = cmd;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Per-cycle comparison of both DUTs against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid_256", int'(tx0), int'(exp_tx[0]));
            check("dout_256", int'(dout0), int'(exp_dout[0]));
            check("tx_valid_128", int'(tx1), int'(exp_tx[1]));
            check("dout_128", int'(dout1), int'(exp_dout[1]));
            if (tx0) begin
                if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
                else check("rd_queue", int'(dout0), int'(exp_q.pop_front()));
            end
        end
        if (tx0) pulses[0]++;
        if (tx1) pulses[1]++;
    end

    initial begin
        int c0;
        int c1;
        int hold;
        int gap;

        // Reset.
        model_reset();
        repeat (3) tick();
        check("reset_dout", int'(dout0), 0);
        check("reset_tx", int'(tx0), 0);
        check("reset_dout_128", int'(dout1), 0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // Fill every location with random data.
        for (int a = 0; a < 256; a++) begin
            send({2'b00, 8'(a)}, 1, 1);
            send({2'b01, 8'($urandom_range(0, 255))}, 1, 1);
        end

        // Basic write/read.
        c0 = pulses[0];
        send(10'h015, 1, 1);
        send(10'h1A5, 1, 1);
        send(10'h215, 1, 1);
        send(10'h300, 1, 1);
        check("wr_rd_dout", int'(dout0), 8'hA5);
        check("wr_rd_pulse", pulses[0] - c0, 1);

        // Asynchronous reset while a read pulse is active.
        send(10'h215, 1, 1);
        din = 10'h300;
        rx_valid = 1'b1;
        tick();
        check("pre_reset_tx", int'(tx0), 1);
        check("pre_reset_dout", int'(dout0), 8'hA5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_async_tx", int'(tx0), 0);
        check("reset_async_dout", int'(dout0), 0);
        rx_valid = 1'b0;
        tick();
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();

        // Release with rx_valid already high: this counts as a command.
        din = 10'h300;
        rx_valid = 1'b1;
        c0 = pulses[0];
        rst_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        check("release_pulse", pulses[0] - c0, 1);

        // Held rx_valid executes once.
        c0 = pulses[0];
        send(10'h300, 12, 1);
        check("held_pulse", pulses[0] - c0, 1);

        // Top address, and out-of-range on the 128-deep RAM.
        c1 = pulses[1];
        send(10'h0FF, 1, 1);
        send(10'h13C, 1, 1);
        send(10'h2FF, 1, 1);
        send(10'h300, 1, 1);
        check("top_addr_dout", int'(dout0), 8'h3C);
        check("oor_dout_128", int'(dout1), 8'h00);
        check("oor_pulse_128", pulses[1] - c1, 1);

        // Consecutive writes after one address command.
        send(10'h0FF, 1, 1);
        send(10'h111, 1, 1);
        send(10'h122, 1, 1);
        send(10'h2FF, 1, 1);
        send(10'h300, 1, 1);
`ifdef RAM_ADDR_AUTOINC_EN
        check("autoinc_ff", int'(dout0), 8'h11);
        send(10'h300, 1, 1);
        check("autoinc_00", int'(dout0), 8'h22);
`else
        check("noinc_ff", int'(dout0), 8'h22);
`endif

        // Back-to-back strobes with rx_valid toggling 1,0,1.
        send(10'h040, 1, 1);
        send(10'h15A, 1, 1);
        send(10'h240, 1, 1);
        send(10'h300, 1, 1);
        check("b2b_dout", int'(dout0), 8'h5A);

        // Random command stream, including held levels and zero-gap repeats.
        for (int i = 0; i < 400; i++) begin
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 2);
            send(10'($urandom_range(0, 1023)), hold, gap);
        end
        rx_valid = 1'b0;
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
